// File: rtl/rx_iq_serializer.sv
// rx_iq_serializer: buffers 48-bit RX IQ samples (I = [47:24], Q = [23:0]) in
// an on-chip FIFO and emits them MSB-first as a stream of 9-bit byte words.
// Optional feature macro: RX_IQ_SYNC_MARK_EN -- when defined, out_tdata[8]
// marks byte 0 (I MSB) of every sample; when undefined, out_tdata[8] is 0.
module rx_iq_serializer #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned BLOCK = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [47:0]                    in_tdata,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  output logic [8:0]                     out_tdata,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic                           rd_allowed,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic                           overflow,
  input  logic                           ovf_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT
  } state_t;

  logic [47:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [47:0]   rd_data;
  logic [47:0]   shreg;
  logic [2:0]    idx;
  state_t        state;

  logic wr_en;
  logic rd_en;
  logic hs;
  logic last_hs;
  logic sync_bit;

  // Ready is derived from the registered count, so a write into a full FIFO
  // is dropped even when a read is issued in the same cycle.
  assign in_tready = (count != CW'(DEPTH));

  // Handshake and FIFO access strobes; a read is issued on every entry to FETCH.
  always_comb begin
    hs      = 1'b0;
    last_hs = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    hs      = out_tvalid && out_tready;
    last_hs = hs && (state == S_SHIFT) && (idx == 3'd5);
    wr_en   = in_tvalid && in_tready;
    rd_en   = (count != '0) && ((state == S_IDLE) || last_hs);
  end

  // Sample RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_tdata;
    end
  end

  // Sample RAM registered read port; data is ready at the end of FETCH.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status flags: level/rd_allowed lag count by one cycle; overflow is sticky
  // and a new drop takes priority over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_allowed <= 1'b0;
      level      <= '0;
      overflow   <= 1'b0;
    end else begin
      rd_allowed <= (count >= CW'(BLOCK));
      level      <= count;
      if (in_tvalid && !in_tready) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Serializer FSM: fetch a sample, then shift out six bytes MSB-first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      idx        <= '0;
      out_tvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          shreg      <= rd_data;
          idx        <= 3'd0;
          out_tvalid <= 1'b1;
          state      <= S_SHIFT;
        end
        S_SHIFT: begin
          if (hs) begin
            shreg <= {shreg[39:0], 8'h00};
            if (idx == 3'd5) begin
              idx        <= 3'd0;
              out_tvalid <= 1'b0;
              state      <= (count != '0) ? S_FETCH : S_IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          out_tvalid <= 1'b0;
        end
      endcase
    end
  end

  // Sync mark on byte 0 of each sample (only while a byte is presented).
`ifdef RX_IQ_SYNC_MARK_EN
  assign sync_bit = out_tvalid && (idx == 3'd0);
`else
  assign sync_bit = 1'b0;
`endif

  // Byte word output, held stable by shreg/idx until the handshake.
  assign out_tdata = {sync_bit, shreg[47:40]};

endmodule
